// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store sequencer with IDLE/BUSY/DONE handshake to a data memory.
// Define MEM_SUBWORD_EN for byte/halfword lanes, load extension and misalign detection.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReadM,
    input  logic        memWriteM,
    input  logic [1:0]  memSizeM,
    input  logic        memUnsignedM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] readDataM,
    output logic        stallM,
    output logic        misalignM
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_next;
    logic        w_access, w_misalign, w_launch;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;

    assign w_access = memReadM | memWriteM;
`ifdef MEM_SUBWORD_EN
    logic [1:0]  r_size, r_lane;
    logic        r_uns;
    logic [31:0] w_shifted;
    assign w_misalign = (memSizeM == 2'b01) ? aluOutM[0] : (memSizeM[1] & |aluOutM[1:0]);
    assign w_be = (memSizeM == 2'b00) ? 4'b0001 << aluOutM[1:0] :
                  (memSizeM == 2'b01) ? 4'b0011 << aluOutM[1:0] : 4'b1111;
    assign w_wdata = (memSizeM == 2'b00) ? {4{writeDataM[7:0]}} :
                     (memSizeM == 2'b01) ? {2{writeDataM[15:0]}} : writeDataM;
    assign w_shifted = dmem_rdata >> {r_lane, 3'b000};
    assign w_load = (r_size == 2'b00) ? {{24{~r_uns & w_shifted[7]}}, w_shifted[7:0]} :
                    (r_size == 2'b01) ? {{16{~r_uns & w_shifted[15]}}, w_shifted[15:0]} : dmem_rdata;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_size <= 2'b00;
            r_lane <= 2'b00;
            r_uns  <= 1'b0;
        end else if (w_launch) begin
            r_size <= memSizeM;
            r_lane <= aluOutM[1:0];
            r_uns  <= memUnsignedM;
        end
    end
`else
    logic w_unused;
    assign w_unused   = ^{memSizeM, memUnsignedM, aluOutM[1:0]};
    assign w_misalign = 1'b0;
    assign w_be       = 4'b1111;
    assign w_wdata    = writeDataM;
    assign w_load     = dmem_rdata;
`endif

    assign w_launch  = (r_state == IDLE) & w_access & ~w_misalign;
    assign dmem_req  = (r_state == BUSY);
    // Stall and misalign are combinational, so gate them with reset to keep them low while held.
    assign stallM    = rst & (w_launch | (r_state == BUSY));
    assign misalignM = rst & (r_state == IDLE) & w_access & w_misalign;

    always_comb begin
        w_next = r_state;
        if (w_launch)
            w_next = BUSY;
        else if (r_state == BUSY && dmem_ack)
            w_next = DONE;
        else if (r_state == DONE)
            w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            readDataM  <= '0;
        end else begin
            if (w_launch) begin
                dmem_we    <= memWriteM;
                dmem_addr  <= {aluOutM[31:2], 2'b00};
                dmem_be    <= w_be;
                dmem_wdata <= w_wdata;
            end
            if (r_state == BUSY && dmem_ack && !dmem_we)
                readDataM <= w_load;
            else if (misalignM)
                readDataM <= '0;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for mem_access against a byte-lane memory model.
module tb_mem_access;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        memReadM = 1'b0, memWriteM = 1'b0, memUnsignedM = 1'b0;
    logic [1:0]  memSizeM = 2'b00;
    logic [31:0] aluOutM = '0, writeDataM = '0;
    logic        dmem_req, dmem_we, stallM, misalignM;
    logic [31:0] dmem_addr, dmem_wdata, readDataM;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;

    mem_access dut (
        .clk(clk), .rst(rst), .memReadM(memReadM), .memWriteM(memWriteM),
        .memSizeM(memSizeM), .memUnsignedM(memUnsignedM), .aluOutM(aluOutM),
        .writeDataM(writeDataM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .readDataM(readDataM),
        .stallM(stallM), .misalignM(misalignM)
    );

    typedef struct {
        logic        mis;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [3:0]  be;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          n_checks = 0, n_pass = 0;
    bit [31:0]   mem[bit [31:0]];
    bit [31:0]   ref_mem[bit [31:0]];
    logic [31:0] last_rd = '0;
    int          ack_wait = 0, rcnt = 0;
    bit          resp_en = 1'b1;
    bit          pend_done = 1'b0, pend_mis = 1'b0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: access width n bytes at lane; misaligned when lane is not a multiple of n.
    task automatic model(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int n, lane;
        logic [31:0] word, v, mask;
`ifdef MEM_SUBWORD_EN
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        lane = int'(a[1:0]);
`else
        n    = 4;
        lane = 0;
`endif
        e.mis  = (lane % n) != 0;
        e.we   = wr;
        e.addr = a & ~32'h3;
        e.be   = 4'(((1 << n) - 1) << lane);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
        word = ref_mem.exists(e.addr) ? ref_mem[e.addr] : dflt(e.addr);
        if (e.mis) begin
            e.rd = '0;
        end else if (wr) begin
            for (int i = 0; i < 4; i++) if (e.be[i]) word[8*i +: 8] = e.wdata[8*i +: 8];
            ref_mem[e.addr] = word;
            e.rd = last_rd;
        end else begin
            v = word >> (8 * lane);
            if (n < 4) begin
                mask = (32'd1 << (8 * n)) - 32'd1;
                v = v & mask;
                if (!uns && v[8*n-1]) v = v | ~mask;
            end
            e.rd = v;
        end
        last_rd = e.rd;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input int w, output exp_t e);
        model(rd, wr, sz, uns, a, wd, e);
        q.push_back(e);
        ack_wait = w;
        memReadM = rd; memWriteM = wr; memSizeM = sz; memUnsignedM = uns;
        aluOutM = a; writeDataM = wd;
    endtask

    task automatic finish(input int exp_stall);
        int c = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!stallM) break;
            c++;
        end
        chk("stall_cycles", c, exp_stall);
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd, input int w);
        exp_t e;
        @(posedge clk); #1;
        issue(rd, wr, sz, uns, a, wd, w, e);
        finish(e.mis ? 0 : 2 + w);
    endtask

    task automatic do_idle();
        @(posedge clk); #1;
        memReadM = 1'b0; memWriteM = 1'b0;
        @(negedge clk);
        chk("idle_stall", stallM, 1'b0);
        chk("idle_req", dmem_req, 1'b0);
    endtask

    // Memory responder: acks after ack_wait extra BUSY cycles, applies writes by byte enable.
    initial forever begin
        @(posedge clk); #2;
        if (resp_en) begin
            if (dmem_req && !dmem_ack) begin
                if (rcnt == ack_wait) begin
                    logic [31:0] w;
                    w = mem.exists(dmem_addr) ? mem[dmem_addr] : dflt(dmem_addr);
                    dmem_rdata = w;
                    if (dmem_we) begin
                        for (int i = 0; i < 4; i++) if (dmem_be[i]) w[8*i +: 8] = dmem_wdata[8*i +: 8];
                        mem[dmem_addr] = w;
                    end
                    dmem_ack = 1'b1;
                    rcnt = 0;
                end else rcnt++;
            end else begin
                dmem_ack = 1'b0;
                rcnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (pend_done) begin
            chk("done_rdata", readDataM, cur.rd);
            chk("done_stall", stallM, 1'b0);
            chk("done_req", dmem_req, 1'b0);
            pend_done = 1'b0;
        end
        if (pend_mis) begin
            chk("mis_rdata_zero", readDataM, '0);
            pend_mis = 1'b0;
        end
        if (rst && dmem_req && dmem_ack) begin
            chk("queue_depth_req", 32'(q.size()), 32'd1);
            if (q.size() != 0) begin
                cur = q.pop_front();
                chk("req_aligned", misalignM, 1'b0);
                chk("req_expected_aligned", cur.mis, 1'b0);
                chk("addr", dmem_addr, cur.addr);
                chk("be", dmem_be, cur.be);
                chk("we", dmem_we, cur.we);
                if (cur.we) chk("wdata", dmem_wdata, cur.wdata);
                pend_done = 1'b1;
            end
        end
        if (misalignM) begin
            chk("queue_depth_mis", 32'(q.size()), 32'd1);
            if (q.size() != 0) begin
                cur = q.pop_front();
                chk("mis_expected", cur.mis, 1'b1);
                chk("mis_req", dmem_req, 1'b0);
                chk("mis_stall", stallM, 1'b0);
                pend_mis = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        memReadM = 1'b1; aluOutM = 32'h105; memSizeM = 2'b10;
        repeat (2) @(negedge clk);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_be", dmem_be, 4'b0000);
        chk("rst_addr", dmem_addr, '0);
        chk("rst_wdata", dmem_wdata, '0);
        chk("rst_rdata", readDataM, '0);
        chk("rst_stall", stallM, 1'b0);
        chk("rst_mis", misalignM, 1'b0);
        memReadM = 1'b0;
        @(negedge clk) rst = 1'b1;

        mem[32'h100] = 32'hDEADBEEF; ref_mem[32'h100] = 32'hDEADBEEF;
        mem[32'h200] = 32'h80112233; ref_mem[32'h200] = 32'h80112233;
        do_access(1, 0, 2'b10, 0, 32'h100, 0, 1);
        chk("word_load_lit", readDataM, 32'hDEADBEEF);
        do_access(1, 0, 2'b00, 0, 32'h203, 0, 0);
`ifdef MEM_SUBWORD_EN
        chk("sbyte_load_lit", readDataM, 32'hFFFFFF80);
`else
        chk("sbyte_load_lit", readDataM, 32'h80112233);
`endif
        do_access(1, 0, 2'b00, 1, 32'h203, 0, 2);
`ifdef MEM_SUBWORD_EN
        chk("ubyte_load_lit", readDataM, 32'h00000080);
`else
        chk("ubyte_load_lit", readDataM, 32'h80112233);
`endif
        do_access(0, 1, 2'b01, 0, 32'h302, 32'h1234ABCD, 0);
        do_access(1, 0, 2'b01, 1, 32'h302, 0, 0);
        do_access(1, 0, 2'b10, 0, 32'h105, 0, 0);
        do_access(1, 0, 2'b01, 0, 32'h107, 0, 0);
        do_idle();

        for (int t = 0; t < 200; t++) begin
            int r;
            if ($urandom_range(0, 3) == 0) do_idle();
            r = $urandom_range(0, 3);
            do_access(r != 1, r == 1 || r == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 255)), $urandom, $urandom_range(0, 3));
        end

        // Abandon an access by reset in its second BUSY cycle, then offer a stray ack.
        @(posedge clk); #1;
        resp_en = 1'b0;
        memReadM = 1'b1; memWriteM = 1'b0; memSizeM = 2'b10; aluOutM = 32'h40;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("busy_req_before_rst", dmem_req, 1'b1);
        rst = 1'b0;
        #1;
        chk("arst_req", dmem_req, 1'b0);
        chk("arst_stall", stallM, 1'b0);
        chk("arst_addr", dmem_addr, '0);
        chk("arst_be", dmem_be, 4'b0000);
        chk("arst_we", dmem_we, 1'b0);
        chk("arst_wdata", dmem_wdata, '0);
        chk("arst_rdata", readDataM, '0);
        chk("arst_mis", misalignM, 1'b0);
        last_rd = '0;
        memReadM = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #2;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("stray_req", dmem_req, 1'b0);
        chk("stray_stall", stallM, 1'b0);
        @(posedge clk); #2;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("stray_rdata", readDataM, '0);
        chk("stray_idle_req", dmem_req, 1'b0);
        rcnt = 0;
        resp_en = 1'b1;

        // Access already presented while in reset launches on the first edge after release.
        @(negedge clk) rst = 1'b0;
        #1;
        issue(1, 0, 2'b10, 0, 32'h100, 0, 0, e);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("release_stall", stallM, 1'b1);
        finish(1);
        do_access(1, 0, 2'b00, 1, 32'h201, 0, 1);
        do_idle();
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
